// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads the instruction SRAM and queues {pc, inst, adel} for decode.
// Define INST_FETCH_SKID_EN for a 2-entry buffer with no out_ready -> inst_sram_en path; default is 1 entry.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adel
);

  typedef enum logic {S_RUN, S_FAULT} state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } entry_t;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  cnt_q, cnt_d, cnt_pop;
  entry_t      ent_q [2];
  entry_t      ent_d [2];
  entry_t      new_ent;
  logic        pop, space, issue, aligned, slot;

  assign pop     = out_valid && out_ready;
  assign aligned = (pc_q[1:0] == 2'b00);

`ifdef INST_FETCH_SKID_EN
  assign space = (cnt_q < 2'd2);
`else
  assign space = (cnt_q == 2'd0) || pop;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_RUN;
    else       state_q <= state_d;
  end

  // Next state: a misaligned issue parks in FAULT until a redirect
  always_comb begin
    state_d = state_q;
    if (redirect_valid)             state_d = S_RUN;
    else if (issue && !aligned)     state_d = S_FAULT;
  end

  // Issue decode and SRAM request
  always_comb begin
    issue          = 1'b0;
    inst_sram_en   = 1'b0;
    inst_sram_wen  = 4'b0000;
    inst_sram_addr = {2'b00, pc_q[31:2]};
    if (!reset && state_q == S_RUN && !redirect_valid && space) issue = 1'b1;
    inst_sram_en   = issue && aligned;
  end

  // PC and buffer next state; redirect flushes, pop shifts head, issue appends
  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ent_d   = ent_q;
    cnt_pop = cnt_q - {1'b0, pop};
    slot    = (cnt_pop == 2'd1);
    new_ent = '{pc: pc_q, inst: aligned ? inst_sram_rdata : 32'h0, adel: !aligned};
    if (redirect_valid) begin
      pc_d  = redirect_pc;
      cnt_d = 2'd0;
    end else begin
      if (pop) ent_d[0] = ent_q[1];
      if (issue) begin
        ent_d[slot] = new_ent;
        if (aligned) pc_d = pc_q + 32'd4;
      end
      cnt_d = cnt_pop + {1'b0, issue};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      cnt_q <= 2'd0;
      for (int i = 0; i < 2; i++) ent_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < 2; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign out_valid = (cnt_q != 2'd0);
  assign out_pc    = ent_q[0].pc;
  assign out_inst  = ent_q[0].inst;
  assign out_adel  = ent_q[0].adel;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; SRAM model returns word index k for address k.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adel;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] A = 32'h2FF0_0000;
`ifdef INST_FETCH_SKID_EN
  localparam int STALL_EN = 1;
`else
  localparam int STALL_EN = 0;
`endif

  inst_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst),
    .out_adel        (out_adel)
  );

  assign inst_sram_rdata = inst_sram_addr;

  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        en;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int en_cnt;
    vecs[0]  = '{1'b0, 32'h0,         1'b1, 1'b1, A,              1'b0, 32'h0,         32'h0,          1'b0};
    vecs[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, A + 32'd1,      1'b1, 32'hBFC0_0000, A,              1'b0};
    vecs[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, A + 32'd2,      1'b1, 32'hBFC0_0004, A + 32'd1,      1'b0};
    vecs[3]  = '{1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, A + 32'd3,      1'b1, 32'hBFC0_0008, A + 32'd2,      1'b0};
    vecs[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h3FFF_FFFF,  1'b0, 32'h0,         32'h0,          1'b0};
    vecs[5]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,          1'b1, 32'hFFFF_FFFC, 32'h3FFF_FFFF,  1'b0};
    vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h1,          1'b1, 32'h0,         32'h0,          1'b0};
    vecs[7]  = '{1'b1, 32'h0000_1002, 1'b1, 1'b0, 32'h2,          1'b1, 32'h4,         32'h1,          1'b0};
    vecs[8]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h400,        1'b0, 32'h0,         32'h0,          1'b0};
    vecs[9]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h400,        1'b1, 32'h0000_1002, 32'h0,          1'b1};
    vecs[10] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h400,        1'b0, 32'h0,         32'h0,          1'b0};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b0, 32'h400,        1'b0, 32'h0,         32'h0,          1'b0};
    vecs[12] = '{1'b1, 32'h0000_2000, 1'b1, 1'b0, 32'h400,        1'b0, 32'h0,         32'h0,          1'b0};
    vecs[13] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h800,        1'b0, 32'h0,         32'h0,          1'b0};
    vecs[14] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h801,        1'b1, 32'h0000_2000, 32'h800,        1'b0};
    vecs[15] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h802,        1'b1, 32'h0000_2004, 32'h801,        1'b0};

    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    #3;
    chk("rst_en",    32'(inst_sram_en), 32'd0);
    chk("rst_valid", 32'(out_valid),    32'd0);
    chk("rst_pc",    out_pc,            32'h0);
    chk("rst_inst",  out_inst,          32'h0);
    chk("rst_adel",  32'(out_adel),     32'd0);
    next_cycle();
    reset = 1'b0;

    // Table: reset release, wrap, misaligned fault, recovery
    for (int i = 0; i < 16; i++) begin
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      out_ready      = vecs[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_en", i),    32'(inst_sram_en),  32'(vecs[i].en));
      chk($sformatf("v%0d_addr", i),  inst_sram_addr,     vecs[i].addr);
      chk($sformatf("v%0d_wen", i),   32'(inst_sram_wen), 32'd0);
      chk($sformatf("v%0d_valid", i), 32'(out_valid),     32'(vecs[i].valid));
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_pc", i),   out_pc,         vecs[i].pc);
        chk($sformatf("v%0d_inst", i), out_inst,       vecs[i].inst);
        chk($sformatf("v%0d_adel", i), 32'(out_adel),  32'(vecs[i].adel));
      end
      next_cycle();
    end
    redirect_valid = 1'b0;

    // Back-pressure: stall 5 cycles, then drain in order
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    out_ready      = 1'b1;
    @(negedge clk);
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("bp_first_en",   32'(inst_sram_en), 32'd1);
    chk("bp_first_addr", inst_sram_addr,    32'h0000_0C00);
    next_cycle();
    out_ready = 1'b0;
    en_cnt    = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_pc", i),    out_pc,         32'h0000_3000);
      if (inst_sram_en) en_cnt++;
      if (i == 4) chk("stall_full_en", 32'(inst_sram_en), 32'd0);
      next_cycle();
    end
    chk("stall_issue_count", 32'(en_cnt), 32'(STALL_EN));
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("drain%0d_pc", k),    out_pc,   32'h0000_3000 + 32'(4 * k));
      chk($sformatf("drain%0d_inst", k),  out_inst, 32'h0000_0C00 + 32'(k));
      next_cycle();
    end

    // Redirect with the buffer held full
    out_ready = 1'b0;
    next_cycle();
    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_1000;
    @(negedge clk);
    chk("redir_en", 32'(inst_sram_en), 32'd0);
    next_cycle();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    @(negedge clk);
    chk("redir_valid", 32'(out_valid),    32'd0);
    chk("redir_addr",  inst_sram_addr,    32'h0000_0400);
    chk("redir_en1",   32'(inst_sram_en), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("redir_head_valid", 32'(out_valid), 32'd1);
    chk("redir_head_pc",    out_pc,         32'h0000_1000);
    chk("redir_head_inst",  out_inst,       32'h0000_0400);

    // Async reset pulse mid-stream
    #2;
    reset = 1'b1;
    #1;
    chk("areset_valid", 32'(out_valid),    32'd0);
    chk("areset_en",    32'(inst_sram_en), 32'd0);
    chk("areset_pc",    out_pc,            32'h0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rel_en",    32'(inst_sram_en), 32'd1);
    chk("rel_addr",  inst_sram_addr,    A);
    chk("rel_valid", 32'(out_valid),    32'd0);
    next_cycle();
    @(negedge clk);
    chk("rel_head_valid", 32'(out_valid), 32'd1);
    chk("rel_head_pc",    out_pc,         32'hBFC0_0000);
    chk("rel_head_inst",  out_inst,       A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the MIPS core. It owns the program counter and drives the read side of the instruction SRAM. It captures each returned word together with its PC into a small output buffer. It hands instructions to decode over a valid/ready handshake, with redirect (branch/exception) support and misaligned-PC fault reporting.

## Interface

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset; must be word-aligned.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- redirect_valid  in  1  load redirect_pc and flush this cycle.
- redirect_pc  in  32  new fetch byte address.
- inst_sram_en  out  1  SRAM read enable.
- inst_sram_wen  out  4  SRAM write enables; constant 4'b0000.
- inst_sram_addr  out  32  SRAM word index, {2'b00, pc[31:2]}.
- inst_sram_rdata  in  32  SRAM read data, valid combinationally in the same cycle as inst_sram_en/addr.
- out_valid  out  1  buffer head holds an entry.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  32  PC of head entry.
- out_inst  out  32  instruction of head entry; 0 for fault entries.
- out_adel  out  1  head is a misaligned-fetch fault entry.

## Operation

- State register: RUN or FAULT.
- pc register: next fetch byte address.
- Output buffer: FIFO of {pc, inst, adel} entries. Depth is set by the configuration macro.
- Issue condition: state == RUN, and !redirect_valid, and space.
  - space: the buffer is not full, per the configuration rules.
- On issue with pc[1:0] == 2'b00:
  - inst_sram_en = 1.
  - Push {pc, inst_sram_rdata, 0}.
  - pc <= pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- On issue with pc[1:0] != 0:
  - inst_sram_en = 0.
  - Push {pc, 32'h0, 1}.
  - state <= FAULT; pc holds.
- FAULT: no issue, inst_sram_en = 0. It leaves FAULT only through a redirect.
- Pop: when out_valid && out_ready.
- Redirect, in the same cycle:
  - Flush all buffer entries.
  - pc <= redirect_pc; state <= RUN.
  - No issue; inst_sram_en = 0.
  - The first fetch from redirect_pc happens the following cycle.
  - A pop in the redirect cycle is still treated as consumed by decode.
- When not issuing, inst_sram_en = 0 and inst_sram_addr still reflects pc.

## Timing

- Reset values: pc = RESET_PC, state = RUN, buffer empty, out_valid = 0, out_pc = 0, out_inst = 0, out_adel = 0, inst_sram_en = 0.
- First issue happens in the first clock cycle after reset deasserts, with addr = RESET_PC>>2.
- Latency: a word issued in cycle N is visible at out_* in cycle N+1 if the buffer was empty.
- Throughput: one instruction per cycle while out_ready stays high.
- Priority: reset over redirect; redirect over pop and issue.
- Reset asserted mid-operation clears everything immediately. Any partially handshaken entry is lost.
- Full buffer with out_ready low: no issue, and pc and buffer contents hold.
- out_* stay stable while out_valid && !out_ready.

## Configuration

- INST_FETCH_SKID_EN defined:
  - Buffer depth is 2; space = (count < 2).
  - No combinational path from out_ready to inst_sram_en.
- INST_FETCH_SKID_EN undefined:
  - Buffer depth is 1; space = (count == 0) || (out_valid && out_ready).
  - This creates a combinational path from out_ready to inst_sram_en and inst_sram_addr.
- Both variants give identical architectural output sequences for identical out_ready/redirect stimulus. Only the issue timing under back-pressure differs.

## Test plan

- Reset release, out_ready = 1, SRAM word k = k:
  - Cycle 1: addr = 32'h2FF0_0000.
  - Cycle 2: out_valid = 1, out_pc = 32'hBFC0_0000, out_inst = SRAM[32'h2FF0_0000].
  - Then out_pc +4 every cycle.
- out_ready = 0 for 5 cycles after the first fetch:
  - SKID: two entries buffered, then inst_sram_en = 0.
  - No SKID: one entry buffered, then inst_sram_en = 0.
  - On out_ready = 1, the PCs resume in order with no gaps or duplicates.
- redirect_valid with redirect_pc = 32'h0000_1000 while 2 entries are buffered:
  - Next cycle: out_valid = 0, addr = 32'h0000_0400.
  - Cycle after: out_pc = 32'h0000_1000.
- redirect_pc = 32'h0000_1002:
  - One entry with out_adel = 1, out_inst = 0, out_pc = 32'h0000_1002.
  - inst_sram_en stays 0 until the next redirect, to 32'h0000_2000, which resumes fetching.
- pc = 32'hFFFF_FFFC via redirect:
  - Entries with out_pc = 32'hFFFF_FFFC, then 32'h0000_0000.
- Async reset pulse mid-stream while out_valid = 1:
  - out_valid drops immediately.
  - Fetching restarts at RESET_PC after release.
